// File: rtl/serial_fa_seq_pkg.sv
// Shared constants for the bit-serial adder sequencer.
package serial_fa_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when bit position idx falls inside the OR-approximated low part.
  function automatic logic in_approx(input logic mode, input int idx, input int nbits);
    return mode && (idx < nbits);
  endfunction

endpackage

// File: rtl/serial_fa_seq_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
interface serial_fa_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, approx_en, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, approx_en, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_fa_seq_fa.sv
// 1-bit full adder, purely combinational.
// Latency: 0 cycles. Backpressure: none.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_fa_seq.sv
// Bit-serial WIDTH-bit adder, LSB first, optional lower-part-OR approximation.
// Latency: out_valid rises WIDTH edges after accept; II = WIDTH+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_fa_seq
  import serial_fa_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_fa_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_param_err
    $error("serial_fa_seq: need WIDTH >= 2 and 0 <= APPROX_BITS <= WIDTH");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic             mode;
  logic [CW-1:0]    bitcnt;
  logic [31:0]      bit_idx;

  logic accept;
  logic last_bit;
  logic approx_bit;
  logic approx_last;
  logic s_fa;
  logic c_fa;
  logic s_bit;
  logic c_bit;

  assign accept      = (state == ST_IDLE) && bus.in_valid;
  assign last_bit    = (bitcnt == CW'(WIDTH - 1));
  assign bit_idx     = 32'(bitcnt);
  assign approx_bit  = in_approx(mode, bit_idx, APPROX_BITS);
  assign approx_last = (bit_idx == 32'(APPROX_BITS - 1));

  fa u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (s_fa),
    .carry (c_fa)
  );

  // Low part: OR for the sum, carry only leaves from the top approximated bit.
  always_comb begin
    s_bit = s_fa;
    c_bit = c_fa;
    if (approx_bit) begin
      s_bit = a_sh[0] | b_sh[0];
      c_bit = approx_last ? (a_sh[0] & b_sh[0]) : 1'b0;
    end
  end

  // New bit enters at the MSB side; sum_nxt is the full result on the last bit.
  assign sum_nxt = {s_bit, sum_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = bus.in_valid ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = bus.out_ready ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ST_IDLE: bus.in_ready  = 1'b1;
      ST_DONE: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // sum_q/cout_q only change on the last bit so the previous result stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      mode   <= 1'b0;
      bitcnt <= '0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      mode   <= bus.approx_en;
      carry  <= (bus.approx_en && APPROX_BITS > 0) ? 1'b0 : bus.cin;
      bitcnt <= '0;
      sum_sh <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nxt[WIDTH-1:1];
      carry  <= c_bit;
      if (last_bit) begin
        sum_q  <= sum_nxt;
        cout_q <= c_bit;
      end else begin
        bitcnt <= bitcnt + CW'(1);
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_fa_seq.sv
// Randomized bench for serial_fa_seq against an arithmetic reference model.
module tb_serial_fa_seq;

  localparam int W  = 8;
  localparam int AB = 4;

  logic clk = 1'b0;
  logic rst;

  serial_fa_seq_if #(.WIDTH(W)) bus ();

  serial_fa_seq #(.WIDTH(W), .APPROX_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {cout, sum} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic ap);
    int unsigned ua, ub, lo, c, hi, r;
    ua = 32'(a);
    ub = 32'(b);
    if (ap && AB > 0) begin
      lo = (ua | ub) & ((32'd1 << AB) - 32'd1);
      c  = (ua >> (AB - 1)) & (ub >> (AB - 1)) & 32'd1;
      hi = (ua >> AB) + (ub >> AB) + c;
      r  = (hi << AB) | lo;
    end else begin
      r = ua + ub + 32'(ci);
    end
    return (W+1)'(r);
  endfunction

  logic [W:0] expq[$];
  logic [W:0] last_res;
  int         busy;
  int         age;

  always @(posedge clk) begin
    if (!rst) begin
      if (busy != 0) age++;
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.a, bus.b, bus.cin, bus.approx_en));
        busy = 1;
        age  = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() > 0) last_res = expq.pop_front();
        busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(busy == 0));
      chk("out_valid", 32'(bus.out_valid), 32'(busy != 0 && age >= W));
      if (busy != 0 && age >= W && expq.size() > 0)
        chk("result", 32'({bus.cout, bus.sum}), 32'(expq[0]));
      else
        chk("held", 32'({bus.cout, bus.sum}), 32'(last_res));
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic ap, input int hold, output logic [W:0] got, output int lat);
    int n;
    got = '0;
    lat = -1;
    n   = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: in_ready stuck at 0");
      return;
    end
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = ci;
    bus.approx_en = ap;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.cin       = 1'($urandom);
    bus.approx_en = 1'($urandom);
    if (hold == 0) bus.out_ready = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      bus.a = W'($urandom);
    end
    if (!bus.out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: out_valid stuck at 0");
      bus.out_ready = 1'b0;
      return;
    end
    got = {bus.cout, bus.sum};
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [W:0] got;
  int         lat;
  logic [W-1:0] ra, rb;
  logic         rc, rp;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.approx_en = 1'b0;
    bus.out_ready = 1'b0;
    busy          = 0;
    age           = 0;
    last_res      = '0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_ff01", 32'(model(8'hFF, 8'h01, 1'b0, 1'b0)), 32'h100);
    chk("model_ffff", 32'(model(8'hFF, 8'hFF, 1'b1, 1'b0)), 32'h1FF);
    chk("model_0f01_ap", 32'(model(8'h0F, 8'h01, 1'b0, 1'b1)), 32'h00F);
    chk("model_0f01_ex", 32'(model(8'h0F, 8'h01, 1'b0, 1'b0)), 32'h010);
    chk("model_8808_ap", 32'(model(8'h88, 8'h08, 1'b1, 1'b1)), 32'h098);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, got, lat);
    chk("d1_res", 32'(got), 32'h100);
    chk("d1_lat", lat, W);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1, got, lat);
    chk("d2_res", 32'(got), 32'h1FF);
    run_op(8'h0F, 8'h01, 1'b0, 1'b1, 0, got, lat);
    chk("d3_approx", 32'(got), 32'h00F);
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, got, lat);
    chk("d3_exact", 32'(got), 32'h010);
    run_op(8'h88, 8'h08, 1'b1, 1'b1, 0, got, lat);
    chk("d4_res", 32'(got), 32'h098);
    run_op(8'h5A, 8'h33, 1'b1, 1'b0, 5, got, lat);
    chk("bp_res", 32'(got), 32'h08E);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, got, lat);
    chk("b2b_res", 32'(got), 32'h046);
    chk("b2b_lat", lat, W);

    // Reset while the block is on bit 3 of a transaction.
    bus.in_valid = 1'b1;
    bus.a        = 8'hC3;
    bus.b        = 8'h5D;
    bus.cin      = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    expq.delete();
    busy     = 0;
    age      = 0;
    last_res = '0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_sum", 32'(bus.sum), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_op(8'hC3, 8'h5D, 1'b1, 1'b0, 0, got, lat);
    chk("post_rst_res", 32'(got), 32'h121);

    for (int k = 0; k < 150; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rp = 1'($urandom);
      run_op(ra, rb, rc, rp, int'($urandom_range(0, 3)), got, lat);
      chk("rand_lat", lat, W);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_fa_seq.md
# serial_fa_seq

Bit-serial addition sequencer that time-shares one 1-bit full adder (`fa`) across a WIDTH-bit operand pair, one bit per clock, LSB first. It has an optional lower-part-OR approximation for the low APPROX_BITS bits, used for approximate accumulation in the DNN datapath. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 8, operand and result width; must be ≥ 2.
- APPROX_BITS, 4, number of low bits approximated when `approx_en` = 1; legal range 0..WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair and controls valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- approx_en  in  1  selects approximate mode for this operation.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- IDLE → RUN on `in_valid && in_ready`. At that edge the block:
  - latches a and b into shift registers;
  - latches `approx_en` into `mode`;
  - sets `carry` to `cin`, or to 0 if `mode`=1 and APPROX_BITS>0;
  - clears `bitcnt` and the sum shift register.
- RUN processes bit i = `bitcnt` on each edge, for i = 0..WIDTH-1:
  - Exact (`mode`=0, or i ≥ APPROX_BITS): `s_i`, `c_next` = fa(a_i, b_i, `carry`); `carry` <= `c_next`.
  - Approx (`mode`=1 and i < APPROX_BITS): `s_i` = a_i | b_i. `carry` <= a_i & b_i if i = APPROX_BITS-1, else 0.
  - `s_i` is shifted into the sum register MSB side (shift right), so bit 0 ends up at sum[0].
  - `bitcnt` increments; after the edge processing i = WIDTH-1, go to DONE.
- DONE:
  - `sum` = assembled result; `cout` = final `carry`.
  - Both are held stable while `out_valid` && !`out_ready`.
  - DONE → IDLE on `out_ready`.
- APPROX_BITS = WIDTH with `mode`=1: `cout` = a[WIDTH-1] & b[WIDTH-1], and `cin` is ignored.
- APPROX_BITS = 0: `approx_en` has no effect.
- `sum` and `cout` retain the last result in IDLE and RUN. Only `out_valid` qualifies them.
- `in_valid` is ignored outside IDLE; `out_ready` is ignored outside DONE.
- Operands must not be sampled from the ports after the accept edge; changes to a/b/cin during RUN have no effect.

## Timing
- Reset values: `state`=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `carry`=0, `bitcnt`=0.
- Latency: accept at edge T; `out_valid` rises after edge T+WIDTH.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH bit cycles, then a same-cycle DONE handshake followed by IDLE.
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`. Handshake outputs decode from registered state only.
- An asynchronous `rst` in any state returns to reset values immediately. The partial result is discarded and no `out_valid` pulse follows.
- `bitcnt` width is $clog2(WIDTH); the terminal compare is against WIDTH-1, with no wrap past it.

## Structure
- Shared constants file: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2). Illegal state 2'd3 recovers to IDLE.
- Sub-module: instantiate the existing 1-bit full adder `fa` (a, b, c, sum, carry) exactly once. The approximate path is a local OR/AND beside it.
- Parameter check at elaboration: APPROX_BITS ≤ WIDTH, else `$error`.

## Test plan
WIDTH=8, APPROX_BITS=4.
- a=0xFF, b=0x01, cin=0, approx_en=0 → sum=0x00, cout=1, `out_valid` exactly 8 cycles after the accept edge.
- a=0xFF, b=0xFF, cin=1, approx_en=0 → sum=0xFF, cout=1; `in_ready`=0 throughout RUN/DONE.
- a=0x0F, b=0x01, approx_en=1 → sum=0x0F, cout=0 (exact result would be 0x10). The same operands with approx_en=0 → 0x10.
- a=0x88, b=0x08, cin=1, approx_en=1 → sum=0x98, cout=0 (cin ignored, low-part carry = 1).
- Hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and a/b → sum/cout stable, `in_ready`=0. Release → IDLE next cycle, then a back-to-back second operation completes correctly.
- Assert `rst` while processing bit 3 → outputs take reset values asynchronously, no `out_valid` follows. The next transaction after reset yields the correct result.
